// File: rtl/crd_hold_pkg.sv
// Shared token format, FSM/rule encodings and token classifiers for crd_hold.
// Optional simulation assertions in crd_hold are enabled by CRD_HOLD_ASSERT_EN.
package crd_hold_pkg;

    localparam int TOK_W        = 17;
    localparam int TOK_CTRL_BIT = 16;

    typedef logic [TOK_W-1:0] token_t;

    localparam token_t TOK_DONE = 17'h10100;

    typedef enum logic [1:0] {
        START,
        PROCESS,
        DONE
    } hold_state_e;

    // Which processing rule fires this cycle; RULE_NONE means stall.
    typedef enum logic [2:0] {
        RULE_NONE,
        RULE_DROP_OUTER,
        RULE_PAIR,
        RULE_STOP,
        RULE_DONE,
        RULE_DRAIN
    } rule_e;

    function automatic logic is_data(token_t t);
        return !t[TOK_CTRL_BIT];
    endfunction

    function automatic logic is_stop(token_t t);
        return t[TOK_CTRL_BIT] && (t[15:8] == 8'h00);
    endfunction

    function automatic logic is_done(token_t t);
        return t == TOK_DONE;
    endfunction

endpackage

// File: rtl/reg_fifo.sv
// Two-entry register FIFO for 17-bit tokens; a pop and a push in the same
// cycle are accepted even when full (pop-then-push).
module reg_fifo
    import crd_hold_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [16:0] wdata,
    output logic [16:0] rdata,
    output logic        full,
    output logic        empty
);

    token_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset too, so the output data reads 0 out of reset.
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/crd_hold.sv
// Coordinate hold: passes the inner stream through and repeats the current
// outer coordinate once per inner token. Assertions: define CRD_HOLD_ASSERT_EN.
module crd_hold
    import crd_hold_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        tile_en,
    input  logic        cmrg_enable,
    input  logic [15:0] cmrg_stop_lvl,
    input  logic [16:0] cmrg_coord_in_0,
    input  logic        cmrg_coord_in_0_valid,
    output logic        cmrg_coord_in_0_ready,
    input  logic [16:0] cmrg_coord_in_1,
    input  logic        cmrg_coord_in_1_valid,
    output logic        cmrg_coord_in_1_ready,
    output logic [16:0] cmrg_coord_out_0,
    output logic        cmrg_coord_out_0_valid,
    input  logic        cmrg_coord_out_0_ready,
    output logic [16:0] cmrg_coord_out_1,
    output logic        cmrg_coord_out_1_valid,
    input  logic        cmrg_coord_out_1_ready
);

    logic        active;
    logic        stop_lvl_unused;
    token_t      in0_head, in1_head, out0_head, out1_head;
    token_t      out0_wdata, out1_wdata;
    logic        in0_full, in0_empty, in1_full, in1_empty;
    logic        out0_full, out0_empty, out1_full, out1_empty;
    logic        in0_push, in1_push, in0_pop, in1_pop;
    logic        out0_push, out1_push, out0_pop, out1_pop;
    logic        can_fire;
    hold_state_e state, state_nxt;
    rule_e       rule;

    assign active          = rst_n & tile_en & cmrg_enable & clk_en;
    assign stop_lvl_unused = ^cmrg_stop_lvl;

    assign cmrg_coord_in_0_ready = active & ~in0_full;
    assign cmrg_coord_in_1_ready = active & ~in1_full;
    assign in0_push = cmrg_coord_in_0_valid & cmrg_coord_in_0_ready;
    assign in1_push = cmrg_coord_in_1_valid & cmrg_coord_in_1_ready;

    assign cmrg_coord_out_0_valid = active & ~out0_empty;
    assign cmrg_coord_out_1_valid = active & ~out1_empty;
    assign out0_pop = cmrg_coord_out_0_valid & cmrg_coord_out_0_ready;
    assign out1_pop = cmrg_coord_out_1_valid & cmrg_coord_out_1_ready;
    assign cmrg_coord_out_0 = out0_head;
    assign cmrg_coord_out_1 = out1_head;

    reg_fifo u_in0 (
        .clk(clk), .rst_n(rst_n), .push(in0_push), .pop(in0_pop),
        .wdata(cmrg_coord_in_0), .rdata(in0_head), .full(in0_full), .empty(in0_empty)
    );
    reg_fifo u_in1 (
        .clk(clk), .rst_n(rst_n), .push(in1_push), .pop(in1_pop),
        .wdata(cmrg_coord_in_1), .rdata(in1_head), .full(in1_full), .empty(in1_empty)
    );
    reg_fifo u_out0 (
        .clk(clk), .rst_n(rst_n), .push(out0_push), .pop(out0_pop),
        .wdata(out0_wdata), .rdata(out0_head), .full(out0_full), .empty(out0_empty)
    );
    reg_fifo u_out1 (
        .clk(clk), .rst_n(rst_n), .push(out1_push), .pop(out1_pop),
        .wdata(out1_wdata), .rdata(out1_head), .full(out1_full), .empty(out1_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= START;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        rule       = RULE_NONE;
        state_nxt  = state;
        out0_push  = 1'b0;
        out1_push  = 1'b0;
        in0_pop    = 1'b0;
        in1_pop    = 1'b0;
        out0_wdata = in0_head;
        out1_wdata = in0_head;
        can_fire   = active && !out0_full && !out1_full && (state != DONE);

        // START also fires so a token reaches the output FIFO one edge after it lands.
        if (can_fire && !in1_empty && is_stop(in1_head)) begin
            rule = RULE_DROP_OUTER;
        end else if (can_fire && !in0_empty && !in1_empty) begin
            if (is_data(in0_head) && is_data(in1_head))      rule = RULE_PAIR;
            else if (is_stop(in0_head))                      rule = RULE_STOP;
            else if (is_done(in0_head) && is_done(in1_head)) rule = RULE_DONE;
            else if (is_done(in0_head) && is_data(in1_head)) rule = RULE_DRAIN;
        end

        case (rule)
            RULE_DROP_OUTER: in1_pop = 1'b1;
            RULE_PAIR: begin
                out0_push  = 1'b1;
                out1_push  = 1'b1;
                out1_wdata = in1_head;
                in0_pop    = 1'b1;
            end
            RULE_STOP, RULE_DONE: begin
                out0_push = 1'b1;
                out1_push = 1'b1;
                in0_pop   = 1'b1;
                in1_pop   = 1'b1;
            end
            RULE_DRAIN: in1_pop = 1'b1;
            default: ;
        endcase

        case (state)
            START: begin
                if (rule == RULE_DONE)                            state_nxt = DONE;
                else if (active && (!in0_empty || !in1_empty))    state_nxt = PROCESS;
            end
            PROCESS: if (rule == RULE_DONE) state_nxt = DONE;
            DONE:    if (active) state_nxt = START;
            default: state_nxt = START;
        endcase
    end

`ifdef CRD_HOLD_ASSERT_EN
    a_quiet_in_reset: assert property (@(posedge clk)
        !rst_n |-> !(cmrg_coord_out_0_valid || cmrg_coord_out_1_valid));
    a_push_pair: assert property (@(posedge clk) disable iff (!rst_n)
        out0_push == out1_push);
    a_done_no_stop: assert property (@(posedge clk) disable iff (!rst_n)
        (rule == RULE_DONE || rule == RULE_DRAIN) |-> !is_stop(in1_head));
    a_in0_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (cmrg_coord_in_0_valid && !cmrg_coord_in_0_ready) |=> $stable(cmrg_coord_in_0));
    a_in1_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (cmrg_coord_in_1_valid && !cmrg_coord_in_1_ready) |=> $stable(cmrg_coord_in_1));
`else
    // Assertions compiled out; the datapath and FSM above are unchanged.
`endif

endmodule

// File: tb/tb_crd_hold.sv
// Randomized self-checking bench for crd_hold against a transaction-level
// model of the hold rules.
module tb_crd_hold;

    localparam logic [16:0] S0   = 17'h10000;
    localparam logic [16:0] DTOK = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1, tile_en = 1'b1, cmrg_enable = 1'b1;
    logic [15:0] stop_lvl = 16'h0;
    logic [16:0] in0_data = '0, in1_data = '0;
    logic        in0_valid = 1'b0, in1_valid = 1'b0;
    logic        in0_ready, in1_ready;
    logic [16:0] out0_data, out1_data;
    logic        out0_valid, out1_valid;
    logic        out0_ready = 1'b1, out1_ready = 1'b1;

    crd_hold dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .tile_en(tile_en),
        .cmrg_enable(cmrg_enable), .cmrg_stop_lvl(stop_lvl),
        .cmrg_coord_in_0(in0_data), .cmrg_coord_in_0_valid(in0_valid),
        .cmrg_coord_in_0_ready(in0_ready),
        .cmrg_coord_in_1(in1_data), .cmrg_coord_in_1_valid(in1_valid),
        .cmrg_coord_in_1_ready(in1_ready),
        .cmrg_coord_out_0(out0_data), .cmrg_coord_out_0_valid(out0_valid),
        .cmrg_coord_out_0_ready(out0_ready),
        .cmrg_coord_out_1(out1_data), .cmrg_coord_out_1_valid(out1_valid),
        .cmrg_coord_out_1_ready(out1_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [16:0] q0[$], q1[$], got0[$], got1[$], exp0[$], exp1[$];
    bit acc0 = 0, acc1 = 0;
    bit rand_src = 0, rand_rdy = 0, rand_clken = 0, saw_block = 0;
    int hold1 = 0, cyc = 0, first_acc = -1, first_vld = -1;

    // Handshake driver and sink: drive just after negedge, sample 1 unit before posedge.
    initial begin : bfm
        forever begin
            @(negedge clk);
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            acc0 = 0;
            acc1 = 0;
            in0_valid = (q0.size() > 0) && (!rand_src || $urandom_range(3) != 0);
            in1_valid = (q1.size() > 0) && (!rand_src || $urandom_range(3) != 0);
            in0_data  = (q0.size() > 0) ? q0[0] : '0;
            in1_data  = (q1.size() > 0) ? q1[0] : '0;
            out0_ready = !rand_rdy || ($urandom_range(3) != 0);
            out1_ready = (hold1 > 0) ? 1'b0 : (!rand_rdy || ($urandom_range(3) != 0));
            if (rand_clken) clk_en = ($urandom_range(7) != 0);
            #4;
            cyc++;
            acc0 = in0_valid && in0_ready;
            acc1 = in1_valid && in1_ready;
            if (first_acc < 0 && (acc0 || acc1)) first_acc = cyc;
            if (first_vld < 0 && out0_valid) first_vld = cyc;
            if (out0_valid && out0_ready) got0.push_back(out0_data);
            if (out1_valid && out1_ready) got1.push_back(out1_data);
            if (hold1 > 0) begin
                if (in0_valid && !in0_ready) saw_block = 1;
                hold1--;
            end
        end
    end

    function automatic bit tok_stop(input logic [16:0] t);
        return t[16] && (t[15:0] < 16'h0100);
    endfunction

    function automatic bit tok_done(input logic [16:0] t);
        return t == DTOK;
    endfunction

    // Applies the hold rules to whole token lists, appending to exp0/exp1.
    task automatic model(input logic [16:0] a[$], input logic [16:0] b[$]);
        logic [16:0] x, y;
        forever begin
            if (b.size() > 0 && tok_stop(b[0])) begin
                void'(b.pop_front());
            end else if (a.size() > 0 && b.size() > 0) begin
                x = a[0];
                y = b[0];
                if (!x[16] && !y[16]) begin
                    exp0.push_back(x); exp1.push_back(y); void'(a.pop_front());
                end else if (tok_stop(x) || (tok_done(x) && tok_done(y))) begin
                    exp0.push_back(x); exp1.push_back(x);
                    void'(a.pop_front()); void'(b.pop_front());
                end else if (tok_done(x) && !y[16]) begin
                    void'(b.pop_front());
                end else begin
                    break;
                end
            end else begin
                break;
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [16:0] a[$], input logic [16:0] b[$]);
        foreach (a[i]) q0.push_back(a[i]);
        foreach (b[i]) q1.push_back(b[i]);
        model(a, b);
    endtask

    task automatic load_basic();
        load('{17'd0, 17'd2, S0, 17'd1, S0, DTOK}, '{17'd5, 17'd7, S0, DTOK});
    endtask

    task automatic wait_got(input string tag, input int n);
        int budget = 300;
        while (got0.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, " wait"}, 32'(got0.size() >= n), 1);
    endtask

    task automatic run_check(input string tag);
        int budget = 2000;
        while ((got0.size() < exp0.size() || got1.size() < exp1.size()) && budget > 0) begin
            tick();
            budget--;
        end
        tick(8);
        check({tag, " count0"}, got0.size(), exp0.size());
        check({tag, " count1"}, got1.size(), exp1.size());
        for (int i = 0; i < exp0.size() && i < got0.size(); i++)
            check($sformatf("%s out0[%0d]", tag, i), got0[i], exp0[i]);
        for (int i = 0; i < exp1.size() && i < got1.size(); i++)
            check($sformatf("%s out1[%0d]", tag, i), got1[i], exp1[i]);
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic load_random();
        logic [16:0] a[$], b[$];
        int nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) begin
            b.push_back({1'b0, 16'($urandom)});
            for (int k = $urandom_range(0, 3); k > 0; k--) a.push_back({1'b0, 16'($urandom)});
            a.push_back({9'h100, 8'($urandom_range(0, 2))});
        end
        if ($urandom_range(3) == 0) b.push_back({1'b0, 16'($urandom)});
        b.push_back({9'h100, 8'($urandom_range(0, 2))});
        a.push_back(DTOK);
        b.push_back(DTOK);
        load(a, b);
    endtask

    int n_before;

    initial begin : main
        #2;
        check("reset out0_valid", out0_valid, 0);
        check("reset out1_valid", out1_valid, 0);
        check("reset in0_ready", in0_ready, 0);
        check("reset in1_ready", in1_ready, 0);
        check("reset out0_data", out0_data, 0);
        check("reset out1_data", out1_data, 0);
        tick(2);
        rst_n = 1'b1;
        tick();
        check("idle in0_ready", in0_ready, 1);
        check("idle in1_ready", in1_ready, 1);

        load_basic();
        run_check("basic");

        first_acc = -1;
        first_vld = -1;
        load('{17'd3, S0, DTOK}, '{17'd9, S0, DTOK});
        run_check("single");
        check("single latency", 32'(first_vld - first_acc), 2);

        load_basic();
        wait_got("bp", 1);
        hold1 = 5;
        out1_ready = 1'b0;
        saw_block = 0;
        run_check("backpressure");
        check("bp in_ready dropped", saw_block, 1);

        load_basic();
        wait_got("rst", 3);
        rst_n = 1'b0;
        #1;
        check("midrst out0_valid", out0_valid, 0);
        check("midrst out1_valid", out1_valid, 0);
        check("midrst in0_ready", in0_ready, 0);
        q0.delete(); q1.delete(); got0.delete(); got1.delete();
        exp0.delete(); exp1.delete();
        acc0 = 0; acc1 = 0; in0_valid = 0; in1_valid = 0;
        tick(2);
        rst_n = 1'b1;
        tick();
        load_basic();
        run_check("after reset");

        tile_en = 1'b0;
        load_basic();
        tick(4);
        check("tile_en=0 in0_ready", in0_ready, 0);
        check("tile_en=0 in1_ready", in1_ready, 0);
        check("tile_en=0 out0_valid", out0_valid, 0);
        check("tile_en=0 nothing out", got0.size(), 0);
        tile_en = 1'b1;
        wait_got("en", 2);
        cmrg_enable = 1'b0;
        n_before = got0.size();
        tick(4);
        check("cmrg_en=0 in0_ready", in0_ready, 0);
        check("cmrg_en=0 out1_valid", out1_valid, 0);
        check("cmrg_en=0 frozen", got0.size(), n_before);
        cmrg_enable = 1'b1;
        run_check("enables");

        load_basic();
        load_basic();
        run_check("back2back");

        rand_src = 1;
        rand_rdy = 1;
        rand_clken = 1;
        for (int it = 0; it < 25; it++) begin
            for (int t = $urandom_range(1, 3); t > 0; t--) load_random();
            run_check($sformatf("rand%0d", it));
        end
        rand_clken = 0;
        clk_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
